// File: rtl/fnd_scan_ctrl.sv
// Scan controller for the Basys3 4-digit FND. Steps through eight slots:
// digits 0-3, then four dot slots on digit 2 that carry a blinking dp.
module fnd_scan_ctrl #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] fnd_bcd,
  input  logic        blink_en,
  output logic [2:0]  fnd_sel,
  output logic [3:0]  fnd_com,
  output logic [7:0]  fnd_data,
  output logic        scan_tick
);

  localparam int DIV  = CLK_FREQ / SCAN_HZ;
  localparam int HALF = SCAN_HZ / (2 * BLINK_HZ);
  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [PW-1:0] r_presc;
  logic [BW-1:0] r_blink_cnt;
  logic          r_phase;
  logic [2:0]    r_sel;
  logic [3:0]    r_com;
  logic [7:0]    r_data;
  logic          r_tick;

  logic          w_term;
  logic [2:0]    w_sel_next;
  logic          w_blink_wrap;
  logic          w_phase_next;
  logic [3:0]    w_nibble;
  logic [7:0]    w_hex_seg;
  logic [3:0]    w_com_next;
  logic [7:0]    w_data_next;

  assign w_term       = en && (r_presc == PW'(DIV - 1));
  assign w_sel_next   = r_sel + 3'd1;
  assign w_blink_wrap = (r_blink_cnt == BW'(HALF - 1));
  // The dot pattern uses the phase that is committed on this same edge.
  assign w_phase_next = w_blink_wrap ? ~r_phase : r_phase;

  always_comb begin
    w_nibble = fnd_bcd[3:0];
    case (w_sel_next[1:0])
      2'd0: w_nibble = fnd_bcd[3:0];
      2'd1: w_nibble = fnd_bcd[7:4];
      2'd2: w_nibble = fnd_bcd[11:8];
      2'd3: w_nibble = fnd_bcd[15:12];
      default: w_nibble = fnd_bcd[3:0];
    endcase
  end

  always_comb begin
    w_hex_seg = 8'hFF;
    case (w_nibble)
      4'h0: w_hex_seg = 8'hC0;
      4'h1: w_hex_seg = 8'hF9;
      4'h2: w_hex_seg = 8'hA4;
      4'h3: w_hex_seg = 8'hB0;
      4'h4: w_hex_seg = 8'h99;
      4'h5: w_hex_seg = 8'h92;
      4'h6: w_hex_seg = 8'h82;
      4'h7: w_hex_seg = 8'hF8;
      4'h8: w_hex_seg = 8'h80;
      4'h9: w_hex_seg = 8'h90;
      4'hA: w_hex_seg = 8'h88;
      4'hB: w_hex_seg = 8'h83;
      4'hC: w_hex_seg = 8'hC6;
      4'hD: w_hex_seg = 8'hA1;
      4'hE: w_hex_seg = 8'h86;
      4'hF: w_hex_seg = 8'h8E;
      default: w_hex_seg = 8'hFF;
    endcase
  end

  always_comb begin
    w_com_next  = 4'b1011;
    w_data_next = 8'hFF;
    if (!w_sel_next[2]) begin
      w_data_next = w_hex_seg;
      case (w_sel_next[1:0])
        2'd0: w_com_next = 4'b1110;
        2'd1: w_com_next = 4'b1101;
        2'd2: w_com_next = 4'b1011;
        2'd3: w_com_next = 4'b0111;
        default: w_com_next = 4'b1111;
      endcase
    end else begin
      w_com_next  = 4'b1011;
      w_data_next = (blink_en && w_phase_next) ? 8'h7F : 8'hFF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc     <= '0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_sel       <= 3'd0;
      r_com       <= 4'b1111;
      r_data      <= 8'hFF;
      r_tick      <= 1'b0;
    end else if (!en) begin
      // Blank the display and freeze all scan state.
      r_com  <= 4'b1111;
      r_data <= 8'hFF;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_term;
      if (w_term) begin
        r_presc     <= '0;
        r_sel       <= w_sel_next;
        r_com       <= w_com_next;
        r_data      <= w_data_next;
        r_phase     <= w_phase_next;
        r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + BW'(1);
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  assign fnd_sel   = r_sel;
  assign fnd_com   = r_com;
  assign fnd_data  = r_data;
  assign scan_tick = r_tick;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl: directed scenarios with literal expectations, then
// randomized en/bcd/blink/reset traffic checked every cycle against a count-based model.
module tb_fnd_scan_ctrl;
  localparam int CLK_FREQ = 100;
  localparam int SCAN_HZ  = 10;
  localparam int BLINK_HZ = 1;
  localparam int DIV  = CLK_FREQ / SCAN_HZ;
  localparam int HALF = SCAN_HZ / (2 * BLINK_HZ);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] fnd_bcd = 16'h0000;
  logic        blink_en = 1'b0;
  logic [2:0]  fnd_sel;
  logic [3:0]  fnd_com;
  logic [7:0]  fnd_data;
  logic        scan_tick;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  fnd_scan_ctrl #(.CLK_FREQ(CLK_FREQ), .SCAN_HZ(SCAN_HZ), .BLINK_HZ(BLINK_HZ)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fnd_bcd(fnd_bcd), .blink_en(blink_en),
    .fnd_sel(fnd_sel), .fnd_com(fnd_com), .fnd_data(fnd_data), .scan_tick(scan_tick)
  );

  always #5 clk = ~clk;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Model: count enabled edges and terminals; slot and blink phase follow
  // directly from the terminal count.
  int         en_edges = 0;
  int         terms = 0;
  logic [2:0] m_sel = 3'd0;
  logic [3:0] m_com = 4'b1111;
  logic [7:0] m_data = 8'hFF;
  logic       m_tick = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      en_edges = 0; terms = 0;
      m_sel = 3'd0; m_com = 4'b1111; m_data = 8'hFF; m_tick = 1'b0;
    end else if (en) begin
      m_tick = ((en_edges % DIV) == DIV - 1);
      en_edges++;
      if (m_tick) begin
        terms++;
        m_sel = 3'(terms % 8);
        if (terms % 8 < 4) begin
          m_com  = ~(4'b0001 << (terms % 8));
          m_data = seg_tab[(fnd_bcd >> (4 * (terms % 8))) & 16'hF];
        end else begin
          m_com  = 4'b1011;
          m_data = (blink_en && ((terms / HALF) % 2 == 1)) ? 8'h7F : 8'hFF;
        end
      end
    end else begin
      m_com = 4'b1111; m_data = 8'hFF; m_tick = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_sel",  32'(fnd_sel),   32'(m_sel));
      chk("model_com",  32'(fnd_com),   32'(m_com));
      chk("model_data", 32'(fnd_data),  32'(m_data));
      chk("model_tick", 32'(scan_tick), 32'(m_tick));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  initial begin
    step(1);
    chk_on = 1'b1;
    step(1);
    chk("rst_sel",  32'(fnd_sel),   32'd0);
    chk("rst_com",  32'(fnd_com),   32'hF);
    chk("rst_data", 32'(fnd_data),  32'hFF);
    chk("rst_tick", 32'(scan_tick), 32'd0);
    rst_n = 1'b1; en = 1'b1; fnd_bcd = 16'h1234; blink_en = 1'b0;

    step(10);
    $display("slot1: sel=%0d com=%b data=%h tick=%b", fnd_sel, fnd_com, fnd_data, scan_tick);
    chk("t1_sel",  32'(fnd_sel),   32'd1);
    chk("t1_com",  32'(fnd_com),   32'b1101);
    chk("t1_data", 32'(fnd_data),  32'hB0);
    chk("t1_tick", 32'(scan_tick), 32'd1);
    step(1);
    chk("t1_tick_off", 32'(scan_tick), 32'd0);
    step(29);
    chk("t4_sel",  32'(fnd_sel),  32'd4);
    chk("t4_data", 32'(fnd_data), 32'hFF);
    blink_en = 1'b1;
    step(10);
    $display("dot slot: sel=%0d com=%b data=%h", fnd_sel, fnd_com, fnd_data);
    chk("t5_com",  32'(fnd_com),  32'b1011);
    chk("t5_dp",   32'(fnd_data), 32'h7F);

    step(3);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("midrst_sel",  32'(fnd_sel),   32'd0);
    chk("midrst_com",  32'(fnd_com),   32'hF);
    chk("midrst_data", 32'(fnd_data),  32'hFF);
    chk("midrst_tick", 32'(scan_tick), 32'd0);
    step(40);
    chk("phase_restart", 32'(fnd_data), 32'hFF);

    step(4);
    en = 1'b0;
    step(1);
    chk("endrop_com",  32'(fnd_com),  32'hF);
    chk("endrop_data", 32'(fnd_data), 32'hFF);
    step(19);
    en = 1'b1;
    step(5);
    chk("enback_sel_held", 32'(fnd_sel), 32'd4);
    chk("enback_blank",    32'(fnd_com), 32'hF);
    step(1);
    $display("resume: sel=%0d com=%b data=%h tick=%b", fnd_sel, fnd_com, fnd_data, scan_tick);
    chk("resume_sel",  32'(fnd_sel),   32'd5);
    chk("resume_tick", 32'(scan_tick), 32'd1);
    chk("resume_data", 32'(fnd_data),  32'h7F);

    fnd_bcd = 16'hABCD;
    step(30);
    chk("abcd_slot0", 32'(fnd_data), 32'hA1);
    step(4);
    fnd_bcd = 16'h0000;
    step(1);
    chk("bcd_nochange", 32'(fnd_data), 32'hA1);
    step(5);
    $display("new bcd: sel=%0d data=%h", fnd_sel, fnd_data);
    chk("bcd_newslot", 32'(fnd_data), 32'hC0);

    for (int i = 0; i < 4000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 24) == 0) fnd_bcd = 16'($urandom);
      if ($urandom_range(0, 199) == 0) blink_en = ~blink_en;
      rst_n = ($urandom_range(0, 999) != 0);
      step(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
